mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the CPU/DMA memory arbiter: FSM states, owner codes, request bundle.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  localparam int MAX_DMA_BURST_DFLT = 4;

  typedef struct packed {
    logic        we;
    logic        bw;
    logic [15:0] addr;
    logic [15:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (CPU/DMA) arbiter in front of a single-port memory; grant edge -> ACCESS -> ACK, 3 cycles per access.
// Requesters hold req until their one-cycle ack; a waiting CPU wins after MAX_DMA_BURST consecutive DMA grants.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_DMA_BURST = MAX_DMA_BURST_DFLT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_bw,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic        dma_bw,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dma_wdata,
  output logic        dma_ack,
  output logic [15:0] dma_rdata,
  output logic [15:0] mem_mab,
  output logic [15:0] mem_mdb_wr,
  output logic        mem_mw,
  output logic        mem_bw,
  input  logic [15:0] mem_mdb_rd,
  output logic        busy,
  output logic        owner
);

  localparam int            CW         = $clog2(MAX_DMA_BURST + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(MAX_DMA_BURST);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_starve;
  logic          r_owner;
  logic [15:0]   r_mab;
  logic [15:0]   r_mdb_wr;
  logic          r_mw;
  logic          r_bw;
  logic [15:0]   r_cpu_rdata;
  logic [15:0]   r_dma_rdata;

  logic          w_grant;
  logic          w_grant_dma;
  logic          w_cpu_ack;
  logic          w_dma_ack;
  req_t          w_sel;
  logic [15:0]   w_rd_dat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_grant_dma = 1'b0;
    w_cpu_ack   = 1'b0;
    w_dma_ack   = 1'b0;
    case (r_state)
      IDLE: begin
        if (cpu_req || dma_req) begin
          w_grant     = 1'b1;
          w_grant_dma = dma_req && !((r_starve == STARVE_MAX) && cpu_req);
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: w_state_nxt = ACK;
      ACK: begin
        w_state_nxt = IDLE;
        w_cpu_ack   = (r_owner == OWN_CPU);
        w_dma_ack   = (r_owner == OWN_DMA);
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_sel    = w_grant_dma ? req_t'{dma_we, dma_bw, dma_addr, dma_wdata}
                                : req_t'{cpu_we, cpu_bw, cpu_addr, cpu_wdata};
  assign w_rd_dat = r_bw ? {8'h00, mem_mdb_rd[7:0]} : mem_mdb_rd;

  // Counts DMA grants that happened while the CPU was kept waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= '0;
    end else if (w_grant) begin
      if (w_grant_dma && cpu_req)
        r_starve <= (r_starve == STARVE_MAX) ? r_starve : r_starve + 1'b1;
      else
        r_starve <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner     <= OWN_CPU;
      r_mab       <= '0;
      r_mdb_wr    <= '0;
      r_mw        <= 1'b0;
      r_bw        <= 1'b0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      r_mw <= 1'b0;
      if (w_grant) begin
        r_owner  <= w_grant_dma ? OWN_DMA : OWN_CPU;
        r_mab    <= w_sel.bw ? w_sel.addr : {w_sel.addr[15:1], 1'b0};
        r_mdb_wr <= w_sel.bw ? {w_sel.wdata[7:0], w_sel.wdata[7:0]} : w_sel.wdata;
        r_bw     <= w_sel.bw;
        r_mw     <= w_sel.we;
      end
      // r_mw is the access direction for the whole ACCESS cycle.
      if ((r_state == ACCESS) && !r_mw) begin
        if (r_owner == OWN_DMA) r_dma_rdata <= w_rd_dat;
        else                    r_cpu_rdata <= w_rd_dat;
      end
    end
  end

  assign cpu_ack    = w_cpu_ack;
  assign dma_ack    = w_dma_ack;
  assign cpu_rdata  = r_cpu_rdata;
  assign dma_rdata  = r_dma_rdata;
  assign mem_mab    = r_mab;
  assign mem_mdb_wr = r_mdb_wr;
  assign mem_mw     = r_mw;
  assign mem_bw     = r_bw;
  assign busy       = (r_state != IDLE);
  assign owner      = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized two-requester run against a transaction-level model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_bw;
  logic [15:0] cpu_addr, cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        dma_req, dma_we, dma_bw;
  logic [15:0] dma_addr, dma_wdata;
  logic        dma_ack;
  logic [15:0] dma_rdata;
  logic [15:0] mem_mab, mem_mdb_wr, mem_mdb_rd;
  logic        mem_mw, mem_bw, busy, owner;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_DMA_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_bw(cpu_bw), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_bw(dma_bw), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_mab(mem_mab), .mem_mdb_wr(mem_mdb_wr), .mem_mw(mem_mw), .mem_bw(mem_bw),
    .mem_mdb_rd(mem_mdb_rd), .busy(busy), .owner(owner)
  );

  // Small memory standing in for mem_space; ovr forces a fixed read value.
  logic [15:0] emu [0:7];
  logic        ovr;
  logic [15:0] ovr_dat;
  assign mem_mdb_rd = ovr ? ovr_dat : emu[mem_mab[3:1]];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) emu[i] <= 16'h0000;
    end else if (mem_mw) begin
      if (!mem_bw)        emu[mem_mab[3:1]]       <= mem_mdb_wr;
      else if (mem_mab[0]) emu[mem_mab[3:1]][15:8] <= mem_mdb_wr[15:8];
      else                emu[mem_mab[3:1]][7:0]  <= mem_mdb_wr[7:0];
    end
  end

  function automatic logic [69:0] all_outs();
    return {cpu_ack, dma_ack, busy, owner, mem_mw, mem_bw, mem_mab, mem_mdb_wr, cpu_rdata, dma_rdata};
  endfunction

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_bw = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_bw = 0; dma_addr = 0; dma_wdata = 0;
    ovr = 0; ovr_dat = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1; idle_inputs();
    @(negedge clk); @(negedge clk); rst = 0;
  endtask

  task automatic wait_ack(input logic is_dma, output int cyc);
    cyc = 0;
    while (cyc < 20) begin
      @(posedge clk); #1; cyc++;
      if (is_dma ? dma_ack : cpu_ack) break;
    end
  endtask

  task automatic rand_req(output logic we, output logic bw, output logic [15:0] addr, output logic [15:0] wdata);
    we    = 1'($urandom_range(0, 1));
    bw    = 1'($urandom_range(0, 1));
    addr  = 16'h0200 | 16'($urandom_range(0, 15));
    wdata = 16'($urandom);
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs();
    repeat (2) @(negedge clk);
    total++; if (all_outs() !== 70'd0) begin bad++; $display("FAIL reset_outs got=%h exp=0", all_outs()); end
    rst = 0;
    @(posedge clk); #1;
    total++; if (all_outs() !== 70'd0) begin bad++; $display("FAIL reset_idle got=%h exp=0", all_outs()); end
  endtask

  task automatic test_cpu_word_write();
    int cyc;
    @(negedge clk); cpu_req = 1; cpu_we = 1; cpu_bw = 0; cpu_addr = 16'h0201; cpu_wdata = 16'hA5A5;
    @(posedge clk); #1;
    total++; if (mem_mab !== 16'h0200) begin bad++; $display("FAIL ww_mab got=%h exp=0200", mem_mab); end
    total++; if ({busy, mem_mw, mem_bw, owner, cpu_ack} !== 5'b11000) begin bad++; $display("FAIL ww_access got=%b exp=11000", {busy, mem_mw, mem_bw, owner, cpu_ack}); end
    total++; if (mem_mdb_wr !== 16'hA5A5) begin bad++; $display("FAIL ww_wdata got=%h exp=a5a5", mem_mdb_wr); end
    @(posedge clk); #1;
    total++; if ({mem_mw, cpu_ack, dma_ack} !== 3'b010) begin bad++; $display("FAIL ww_ack got=%b exp=010", {mem_mw, cpu_ack, dma_ack}); end
    cpu_req = 0;
    @(posedge clk); #1;
    total++; if ({busy, cpu_ack, mem_mab} !== {2'b00, 16'h0200}) begin bad++; $display("FAIL ww_idle got=%h exp=00200", {busy, cpu_ack, mem_mab}); end
    @(negedge clk); cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0200; cpu_wdata = 16'h0000;
    wait_ack(1'b0, cyc);
    total++; if (cyc !== 2) begin bad++; $display("FAIL rb_latency got=%0d exp=2", cyc); end
    total++; if (cpu_rdata !== 16'hA5A5) begin bad++; $display("FAIL rb_data got=%h exp=a5a5", cpu_rdata); end
    cpu_req = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_dma_byte_read();
    @(negedge clk); ovr = 1; ovr_dat = 16'h12F0;
    dma_req = 1; dma_we = 0; dma_bw = 1; dma_addr = 16'h0203;
    @(posedge clk); #1;
    total++; if ({mem_mab, mem_bw, mem_mw, owner} !== {16'h0203, 3'b101}) begin bad++; $display("FAIL dr_access got=%h exp=%h", {mem_mab, mem_bw, mem_mw, owner}, {16'h0203, 3'b101}); end
    @(posedge clk); #1;
    total++; if ({dma_ack, cpu_ack} !== 2'b10) begin bad++; $display("FAIL dr_ack got=%b exp=10", {dma_ack, cpu_ack}); end
    total++; if (dma_rdata !== 16'h00F0) begin bad++; $display("FAIL dr_data got=%h exp=00f0", dma_rdata); end
    dma_req = 0; ovr = 0;
    @(posedge clk); #1;
    total++; if ({busy, dma_ack, cpu_rdata} !== {2'b00, 16'hA5A5}) begin bad++; $display("FAIL dr_idle got=%h exp=0a5a5", {busy, dma_ack, cpu_rdata}); end
  endtask

  task automatic test_byte_write();
    @(negedge clk); cpu_req = 1; cpu_we = 1; cpu_bw = 1; cpu_addr = 16'h0205; cpu_wdata = 16'h3377;
    @(posedge clk); #1;
    total++; if (mem_mdb_wr !== 16'h7777) begin bad++; $display("FAIL bw_wdata got=%h exp=7777", mem_mdb_wr); end
    total++; if ({mem_mab, mem_bw, mem_mw} !== {16'h0205, 2'b11}) begin bad++; $display("FAIL bw_ctl got=%h exp=%h", {mem_mab, mem_bw, mem_mw}, {16'h0205, 2'b11}); end
    @(posedge clk); #1;
    total++; if ({cpu_ack, cpu_rdata} !== {1'b1, 16'hA5A5}) begin bad++; $display("FAIL bw_ack got=%h exp=1a5a5", {cpu_ack, cpu_rdata}); end
    cpu_req = 0; cpu_bw = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_addr_hold();
    @(negedge clk); cpu_req = 1; cpu_we = 0; cpu_bw = 0; cpu_addr = 16'h0200;
    @(posedge clk); #1;
    cpu_addr = 16'h0300; cpu_bw = 1; cpu_we = 1;
    #1;
    total++; if ({mem_mab, mem_bw, mem_mw} !== {16'h0200, 2'b00}) begin bad++; $display("FAIL ah_access got=%h exp=%h", {mem_mab, mem_bw, mem_mw}, {16'h0200, 2'b00}); end
    @(posedge clk); #1;
    total++; if ({cpu_ack, mem_mab} !== {1'b1, 16'h0200}) begin bad++; $display("FAIL ah_ack got=%h exp=10200", {cpu_ack, mem_mab}); end
    cpu_req = 0;
    @(posedge clk); #1;
    total++; if ({busy, mem_mab} !== {1'b0, 16'h0200}) begin bad++; $display("FAIL ah_idle got=%h exp=00200", {busy, mem_mab}); end
  endtask

  task automatic test_starvation();
    logic got [$];
    logic exp_own;
    int   s = 0;
    do_reset();
    @(negedge clk);
    cpu_req = 1; cpu_addr = 16'h0200;
    dma_req = 1; dma_addr = 16'h0202;
    for (int cyc = 0; cyc < 60 && got.size() < 10; cyc++) begin
      @(posedge clk); #1;
      if (cpu_ack && dma_ack) begin bad++; total++; $display("FAIL st_dual_ack at cycle %0d", cyc); end
      if (cpu_ack) got.push_back(OWN_CPU);
      if (dma_ack) got.push_back(OWN_DMA);
    end
    cpu_req = 0; dma_req = 0;
    total++; if (got.size() !== 10) begin bad++; $display("FAIL st_count got=%0d exp=10", got.size()); end
    for (int g = 0; g < got.size(); g++) begin
      exp_own = (s == MAXB) ? OWN_CPU : OWN_DMA;
      s = (exp_own == OWN_CPU) ? 0 : ((s < MAXB) ? s + 1 : s);
      total++; if (got[g] !== exp_own) begin bad++; $display("FAIL st_order grant=%0d got=%b exp=%b", g, got[g], exp_own); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk); cpu_req = 1; cpu_we = 1; cpu_bw = 0; cpu_addr = 16'h0212; cpu_wdata = 16'h1234;
    @(posedge clk); #1;
    total++; if (mem_mw !== 1'b1) begin bad++; $display("FAIL ra_pre_mw got=%b exp=1", mem_mw); end
    #1 rst = 1;
    #1;
    total++; if (all_outs() !== 70'd0) begin bad++; $display("FAIL ra_async got=%h exp=0", all_outs()); end
    @(posedge clk); #1;
    total++; if ({cpu_ack, busy, mem_mw} !== 3'b000) begin bad++; $display("FAIL ra_noack got=%b exp=000", {cpu_ack, busy, mem_mw}); end
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    total++; if ({busy, mem_mw, owner, mem_mab} !== {3'b110, 16'h0212}) begin bad++; $display("FAIL ra_regrant got=%h exp=%h", {busy, mem_mw, owner, mem_mab}, {3'b110, 16'h0212}); end
    @(posedge clk); #1;
    total++; if (cpu_ack !== 1'b1) begin bad++; $display("FAIL ra_ack got=%b exp=1", cpu_ack); end
    cpu_req = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [15:0] mmem [0:7];
    int          m_cnt = 0;
    int          m_starve = 0;
    logic        e_owner = OWN_CPU;
    logic        e_we = 0, e_bw = 0;
    logic [15:0] e_addr = 0, e_wdata = 0, e_cpu_rd = 0, e_dma_rd = 0, word, e_mab;
    logic        dma_win;
    do_reset();
    for (int i = 0; i < 8; i++) mmem[i] = emu[i];
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge clk);
      // Transaction-level view: a grant occupies the port for 3 edges.
      if (m_cnt == 0) begin
        if (cpu_req || dma_req) begin
          dma_win = dma_req && !(m_starve == MAXB && cpu_req);
          if (dma_win && cpu_req) m_starve = (m_starve < MAXB) ? m_starve + 1 : m_starve;
          else                    m_starve = 0;
          e_owner = dma_win ? OWN_DMA : OWN_CPU;
          e_we    = dma_win ? dma_we    : cpu_we;
          e_bw    = dma_win ? dma_bw    : cpu_bw;
          e_addr  = dma_win ? dma_addr  : cpu_addr;
          e_wdata = dma_win ? dma_wdata : cpu_wdata;
          m_cnt   = 2;
        end
      end else if (m_cnt == 2) begin
        m_cnt = 1;
        word  = mmem[e_addr[3:1]];
        if (e_we) begin
          if (!e_bw)          mmem[e_addr[3:1]] = e_wdata;
          else if (e_addr[0]) mmem[e_addr[3:1]] = {e_wdata[7:0], word[7:0]};
          else                mmem[e_addr[3:1]] = {word[15:8], e_wdata[7:0]};
        end else if (e_owner == OWN_DMA) begin
          e_dma_rd = e_bw ? {8'h00, word[7:0]} : word;
        end else begin
          e_cpu_rd = e_bw ? {8'h00, word[7:0]} : word;
        end
      end else begin
        m_cnt = 0;
      end
      #1;
      e_mab = e_bw ? e_addr : {e_addr[15:1], 1'b0};
      total++; if ({busy, owner} !== {(m_cnt != 0), e_owner}) begin bad++; $display("FAIL rnd_busy_owner cyc=%0d got=%b exp=%b", cyc, {busy, owner}, {(m_cnt != 0), e_owner}); end
      total++; if ({cpu_ack, dma_ack} !== {(m_cnt == 1 && e_owner == OWN_CPU), (m_cnt == 1 && e_owner == OWN_DMA)}) begin bad++; $display("FAIL rnd_ack cyc=%0d got=%b exp_owner=%b cnt=%0d", cyc, {cpu_ack, dma_ack}, e_owner, m_cnt); end
      total++; if (mem_mw !== (m_cnt == 2 && e_we)) begin bad++; $display("FAIL rnd_mw cyc=%0d got=%b exp=%b", cyc, mem_mw, (m_cnt == 2 && e_we)); end
      total++; if ({mem_mab, mem_bw} !== {e_mab, e_bw}) begin bad++; $display("FAIL rnd_mab cyc=%0d got=%h/%b exp=%h/%b", cyc, mem_mab, mem_bw, e_mab, e_bw); end
      total++; if ({cpu_rdata, dma_rdata} !== {e_cpu_rd, e_dma_rd}) begin bad++; $display("FAIL rnd_rdata cyc=%0d got=%h/%h exp=%h/%h", cyc, cpu_rdata, dma_rdata, e_cpu_rd, e_dma_rd); end
      if (m_cnt != 0) begin
        total++; if (mem_mdb_wr !== (e_bw ? {e_wdata[7:0], e_wdata[7:0]} : e_wdata)) begin bad++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", cyc, mem_mdb_wr, (e_bw ? {e_wdata[7:0], e_wdata[7:0]} : e_wdata)); end
      end
      #1;
      if (cyc >= 1490) begin
        cpu_req = 0; dma_req = 0;
      end else begin
        if (cpu_ack) begin
          if ($urandom_range(0, 1) == 0) cpu_req = 0;
          else begin rand_req(cpu_we, cpu_bw, cpu_addr, cpu_wdata); cpu_req = 1; end
        end else if (!cpu_req) begin
          if ($urandom_range(0, 2) == 0) begin rand_req(cpu_we, cpu_bw, cpu_addr, cpu_wdata); cpu_req = 1; end
        end else if (m_cnt == 2 && e_owner == OWN_CPU && $urandom_range(0, 1) == 1) begin
          rand_req(cpu_we, cpu_bw, cpu_addr, cpu_wdata);
        end
        if (dma_ack) begin
          if ($urandom_range(0, 1) == 0) dma_req = 0;
          else begin rand_req(dma_we, dma_bw, dma_addr, dma_wdata); dma_req = 1; end
        end else if (!dma_req) begin
          if ($urandom_range(0, 1) == 0) begin rand_req(dma_we, dma_bw, dma_addr, dma_wdata); dma_req = 1; end
        end else if (m_cnt == 2 && e_owner == OWN_DMA && $urandom_range(0, 1) == 1) begin
          rand_req(dma_we, dma_bw, dma_addr, dma_wdata);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_cpu_word_write();
    test_dma_byte_read();
    test_byte_write();
    test_addr_hold();
    test_starvation();
    test_reset_mid_access();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
